// File: rtl/conv_1x1_weight_streamer_02.sv
// -----------------------------------------------------------------------------
// conv_1x1_weight_streamer_02
//
// Transmit side of the conv 1x1 weight interface. A host/DMA write stream
// fills a local register file with one filter's weight set. Each start pulse
// then streams the stored set, mem[0] first, on valid_weight_out/weight_out
// with a registered valid/ready handshake toward the conv 1x1 top. The set is
// kept after streaming, so it can be replayed any number of times without a
// reload; only clear (or reset) discards it.
//
// Parameters
//   DATA_WIDTH    width of one weight word
//   WEIGHT_NUM    weights per set
//   POINTER_WIDTH pointer width; 2**POINTER_WIDTH must exceed WEIGHT_NUM so
//                 the read pointer can reach WEIGHT_NUM itself
//
// Ports
//   clk              rising-edge clock
//   reset            asynchronous active-low reset
//   clear            synchronous flush back to IDLE, discards the set
//   wr_valid         write-stream qualifier
//   wr_data          weight word, written sequentially
//   start            one-cycle request to stream the stored set once
//   ready_in         downstream accepts weight_out this cycle
//   weight_out       streamed weight (registered)
//   valid_weight_out weight_out is valid (registered)
//   loaded           full set stored (READY and STREAM)
//   busy             streaming in progress (STREAM)
//   done             one-cycle pulse after the last word is accepted
// -----------------------------------------------------------------------------
module conv_1x1_weight_streamer_02 #(
  parameter int DATA_WIDTH    = 32,
  parameter int WEIGHT_NUM    = 128,
  parameter int POINTER_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  wr_valid,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  start,
  input  logic                  ready_in,
  output logic [DATA_WIDTH-1:0] weight_out,
  output logic                  valid_weight_out,
  output logic                  loaded,
  output logic                  busy,
  output logic                  done
);

  // Register-file address width; the depth is rounded up to a power of two so
  // the address slice always matches the array bounds exactly.
  localparam int ADDR_W    = (WEIGHT_NUM > 1) ? $clog2(WEIGHT_NUM) : 1;
  localparam int MEM_DEPTH = 1 << ADDR_W;

  localparam logic [POINTER_WIDTH-1:0] PTR_ONE  = POINTER_WIDTH'(1);
  localparam logic [POINTER_WIDTH-1:0] PTR_NUM  = POINTER_WIDTH'(WEIGHT_NUM);
  localparam logic [POINTER_WIDTH-1:0] PTR_LAST = POINTER_WIDTH'(WEIGHT_NUM - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_READY  = 2'd2;
  localparam logic [1:0] S_STREAM = 2'd3;

  logic [1:0]               state_q,  state_d;
  logic [POINTER_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [POINTER_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0]    weight_q, weight_d;
  logic                     valid_q,  valid_d;
  logic                     loaded_q, loaded_d;
  logic                     busy_q,   busy_d;
  logic                     done_q,   done_d;

  logic [DATA_WIDTH-1:0]    mem_q [MEM_DEPTH];
  logic                     mem_we;
  logic [DATA_WIDTH-1:0]    mem_rd_data;

  assign mem_rd_data = mem_q[rd_ptr_q[ADDR_W-1:0]];

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    weight_d = weight_q;
    valid_d  = valid_q;
    loaded_d = loaded_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    mem_we   = 1'b0;

    if (clear) begin
      // Flush wins over every other input; weight_out is left as is.
      state_d  = S_IDLE;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      valid_d  = 1'b0;
      loaded_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        // IDLE always holds wr_ptr=0, so it shares the LOAD write path. A
        // one-word set completes on the very first write.
        S_IDLE, S_LOAD: begin
          if (wr_valid) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (wr_ptr_q == PTR_LAST) begin
              state_d  = S_READY;
              loaded_d = 1'b1;
            end else begin
              state_d  = S_LOAD;
            end
          end
        end

        // Writes are ignored here so a stored set can never be corrupted.
        S_READY: begin
          if (start) begin
            rd_ptr_d = '0;
            state_d  = S_STREAM;
            busy_d   = 1'b1;
          end
        end

        // The output register advances when it is empty or being accepted.
        // Once every word has been handed over, the next advance closes the
        // stream instead of loading a word.
        S_STREAM: begin
          if (!valid_q || ready_in) begin
            if (rd_ptr_q < PTR_NUM) begin
              weight_d = mem_rd_data;
              valid_d  = 1'b1;
              rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
              valid_d  = 1'b0;
              done_d   = 1'b1;
              state_d  = S_READY;
              busy_d   = 1'b0;
            end
          end
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      weight_q <= '0;
      valid_q  <= 1'b0;
      loaded_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      weight_q <= weight_d;
      valid_q  <= valid_d;
      loaded_q <= loaded_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Register file has no reset; its contents are only read after a full load.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_ptr_q[ADDR_W-1:0]] <= wr_data;
    end
  end

  assign weight_out       = weight_q;
  assign valid_weight_out = valid_q;
  assign loaded           = loaded_q;
  assign busy             = busy_q;
  assign done             = done_q;

endmodule
